// File: rtl/rca_nibble_seq_adder.sv
// Multi-precision adder that streams two wide operands LS nibble first through
// one shared 4-bit ripple-carry adder, chaining the carry through a register.

module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

module rca_nibble_seq_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic            clear_sum;
    logic            nib_we;

    logic [3:0]      a_nib [NIBBLES];
    logic [3:0]      b_nib [NIBBLES];
    logic [3:0]      rca_sum;
    logic            rca_cout;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_q[4*gi +: 4];
            assign b_nib[gi] = b_q[4*gi +: 4];
            // Only the nibble currently selected by idx is written; the rest hold.
            assign sum_d[4*gi +: 4] = clear_sum ? 4'h0 :
                                      (nib_we && (idx_q == IDXW'(gi))) ? rca_sum :
                                      sum_q[4*gi +: 4];
        end
    endgenerate

    rca_4bit u_rca (
        .a    (a_nib[idx_q]),
        .b    (b_nib[idx_q]),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        cout_d    = cout_q;
        clear_sum = 1'b0;
        nib_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    idx_d     = '0;
                    cout_d    = 1'b0;
                    clear_sum = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                nib_we  = 1'b1;
                carry_d = rca_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = rca_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Status flags decode the state register only, so done is glitch-free.
    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN) || (state_q == S_DONE);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_rca_nibble_seq_adder.sv
// Self-checking bench for rca_nibble_seq_adder (NIBBLES=4): vector table,
// scoreboard queue of expected results, and hand-written abort/ignore sequences.

module tb_rca_nibble_seq_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    rca_nibble_seq_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic do_add(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic [W-1:0] es, input logic ec);
        int   lat;
        bit   seen;
        exp_t e;
        check({nm, " ready_before"}, 32'(ready), 32'd1);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = ci;
        sb.push_back('{sum: es, cout: ec});
        @(posedge clk); #1;
        start = 1'b0;
        a     = ~av;
        b     = W'($urandom);
        cin   = ~ci;
        check({nm, " sum_cleared"}, 32'(sum), 32'd0);
        check({nm, " busy_run"}, 32'(busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            failures++;
            checks++;
            $display("FAIL %s done_timeout got=none exp=done within 20 cycles", nm);
            void'(sb.pop_front());
        end else begin
            check({nm, " latency"}, 32'(lat), 32'(NIBBLES));
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s scoreboard_empty got=done exp=pending entry", nm);
            end else begin
                e = sb.pop_front();
                check({nm, " sum"}, 32'(sum), 32'(e.sum));
                check({nm, " cout"}, 32'(cout), 32'(e.cout));
            end
        end
        @(posedge clk); #1;
        check({nm, " done_pulse"}, 32'(done), 32'd0);
        check({nm, " ready_after"}, 32'(ready), 32'd1);
        $display("txn %s a=%h b=%h cin=%0d -> sum=%h cout=%0d latency=%0d", nm, av, bv, ci, sum, cout, lat);
    endtask

    initial begin
        int   dones;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   model;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h00FE, 16'h00FA, 1'b1, 16'h01F9, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

        // Reset held two cycles with start asserted: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        cin   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ready", 32'(ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("post_reset ready", 32'(ready), 32'd1);
        check("post_reset busy", 32'(busy), 32'd0);
        $display("txn reset done");

        for (int i = 0; i < 8; i++) begin
            do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Result holds through IDLE.
        repeat (3) @(posedge clk);
        #1;
        check("hold sum", 32'(sum), 32'h0000BE01);
        check("hold cout", 32'(cout), 32'd0);
        $display("txn hold sum=%h cout=%0d", sum, cout);

        // Second start while busy is ignored.
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        a     = 16'h7777;
        b     = 16'h7777;
        cin   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                dones++;
                check("ignore sum", 32'(sum), 32'h00000002);
                check("ignore cout", 32'(cout), 32'd0);
            end
            @(posedge clk); #1;
        end
        check("ignore done_count", 32'(dones), 32'd1);
        check("ignore ready", 32'(ready), 32'd1);
        $display("txn ignore_start sum=%h dones=%0d", sum, dones);

        // Reset abort after two RUN cycles.
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(ready), 32'd1);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("abort no_done", 32'(dones), 32'd0);
        $display("txn abort dones=%0d", dones);
        do_add("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rc    = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_add($sformatf("rand%0d", i), ra, rb, rc, model[W-1:0], model[W]);
        end

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
